// File: rtl/mw_cook_scheduler_pkg.sv
// rtl/mw_cook_scheduler_pkg.sv - shared states, constants and power clamp for the cook scheduler
package mw_cook_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COOKING = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam logic [3:0] POWER_MAX           = 4'd10;
  localparam int         DEFAULT_DUTY_PERIOD = 10;
  localparam int         DEFAULT_BEEP_TICKS  = 3;

  // Out-of-range requests (0 or above the top level) run at full power.
  function automatic logic [3:0] clamp_power(input logic [3:0] sel);
    return ((sel == 4'd0) || (sel > POWER_MAX)) ? POWER_MAX : sel;
  endfunction

endpackage

// File: rtl/mw_duty_counter.sv
// rtl/mw_duty_counter.sv - tick-driven duty window phase counter with power compare
module mw_duty_counter
  import mw_cook_scheduler_pkg::*;
#(
  parameter int DUTY_PERIOD = DEFAULT_DUTY_PERIOD,
  parameter int PHASE_W     = (DUTY_PERIOD > 16) ? $clog2(DUTY_PERIOD) : 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       adv,
  input  logic [3:0] power,
  output logic       below
);

  localparam logic [PHASE_W-1:0] LAST = PHASE_W'(DUTY_PERIOD - 1);

  logic [PHASE_W-1:0] phase;

  // Phase holds unless advanced; clear wins over advance.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      phase <= '0;
    end else if (adv) begin
      phase <= (phase == LAST) ? '0 : phase + 1'b1;
    end
  end

  assign below = (phase < PHASE_W'(power));

endmodule

// File: rtl/mw_cook_scheduler.sv
// rtl/mw_cook_scheduler.sv - microwave cook sequencing FSM with magnetron duty cycling and beep
module mw_cook_scheduler
  import mw_cook_scheduler_pkg::*;
#(
  parameter int DUTY_PERIOD = DEFAULT_DUTY_PERIOD,
  parameter int BEEP_TICKS  = DEFAULT_BEEP_TICKS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       door_closed,
  input  logic       timer_zero,
  input  logic [3:0] power_sel,
  output logic       mag_on,
  output logic       count_en,
  output logic       timer_clear,
  output logic       beep,
  output logic       busy
);

  localparam int             PHASE_W   = (DUTY_PERIOD > 16) ? $clog2(DUTY_PERIOD) : 4;
  localparam int             BW        = (BEEP_TICKS > 1) ? $clog2(BEEP_TICKS + 1) : 1;
  localparam logic [BW-1:0]  BEEP_LOAD = BW'(BEEP_TICKS);

  state_t        state;
  logic [3:0]    power_q;
  logic [BW-1:0] beep_cnt;
  logic          phase_clr;
  logic          phase_adv;
  logic          below;

  // Phase restarts on clear or a fresh start; it only advances on a tick
  // while cooking continues, so the entry tick and the pausing tick are lost.
  always_comb begin
    phase_clr = clear || ((state == ST_IDLE) && start && door_closed && !timer_zero);
    phase_adv = tick && (state == ST_COOKING) && !clear && !timer_zero && !stop && door_closed;
  end

  mw_duty_counter #(
    .DUTY_PERIOD (DUTY_PERIOD),
    .PHASE_W     (PHASE_W)
  ) u_duty (
    .clk   (clk),
    .rst   (rst),
    .clr   (phase_clr),
    .adv   (phase_adv),
    .power (power_q),
    .below (below)
  );

  // Sequencing FSM: clear > timer_zero > stop/door-open > start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      power_q     <= POWER_MAX;
      beep_cnt    <= '0;
      timer_clear <= 1'b0;
    end else begin
      timer_clear <= 1'b0;
      if (clear) begin
        state       <= ST_IDLE;
        beep_cnt    <= '0;
        timer_clear <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start && door_closed && !timer_zero) begin
              state   <= ST_COOKING;
              power_q <= clamp_power(power_sel);
            end
          end
          ST_COOKING: begin
            if (timer_zero) begin
              state    <= ST_DONE;
              beep_cnt <= BEEP_LOAD;
            end else if (stop || !door_closed) begin
              state <= ST_PAUSED;
            end
          end
          ST_PAUSED: begin
            if (stop) begin
              state       <= ST_IDLE;
              timer_clear <= 1'b1;
            end else if (start && door_closed) begin
              state   <= ST_COOKING;
              power_q <= clamp_power(power_sel);
            end
          end
          ST_DONE: begin
            if (start || stop) begin
              state <= ST_IDLE;
            end else if (tick) begin
              beep_cnt <= beep_cnt - 1'b1;
              if (beep_cnt <= BW'(1)) begin
                state <= ST_IDLE;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign count_en = (state == ST_COOKING);
  assign beep     = (state == ST_DONE);
  assign busy     = (state != ST_IDLE);
  // Door is gated directly so opening it cuts the magnetron without waiting a clock.
  assign mag_on   = (state == ST_COOKING) && below && door_closed;

endmodule

// File: tb/tb_mw_cook_scheduler.sv
// tb/tb_mw_cook_scheduler.sv - self-checking bench for mw_cook_scheduler
module tb_mw_cook_scheduler;

  localparam int DUTY = 10;
  localparam int BEEPS = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       clear = 1'b0;
  logic       door_closed = 1'b1;
  logic       timer_zero = 1'b0;
  logic [3:0] power_sel = 4'd10;
  logic       mag_on, count_en, timer_clear, beep, busy;

  int checks = 0;
  int failures = 0;

  // Reference model: mode 0 idle, 1 cooking, 2 paused, 3 done
  int m_mode = 0;
  int m_phase = 0;
  int m_power = 10;
  int m_beep = 0;
  bit m_tclr = 0;

  mw_cook_scheduler #(.DUTY_PERIOD(DUTY), .BEEP_TICKS(BEEPS)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .start       (start),
    .stop        (stop),
    .clear       (clear),
    .door_closed (door_closed),
    .timer_zero  (timer_zero),
    .power_sel   (power_sel),
    .mag_on      (mag_on),
    .count_en    (count_en),
    .timer_clear (timer_clear),
    .beep        (beep),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic int level(input int p);
    return (p >= 1 && p <= 10) ? p : 10;
  endfunction

  task automatic model_update();
    m_tclr = 0;
    if (rst) begin
      m_mode = 0; m_phase = 0; m_power = 10; m_beep = 0;
    end else if (clear) begin
      m_mode = 0; m_phase = 0; m_beep = 0; m_tclr = 1;
    end else if (m_mode == 0) begin
      if (start && door_closed && !timer_zero) begin
        m_mode = 1; m_phase = 0; m_power = level(int'(power_sel));
      end
    end else if (m_mode == 1) begin
      if (timer_zero) begin
        m_mode = 3; m_beep = BEEPS;
      end else if (stop || !door_closed) begin
        m_mode = 2;
      end else if (tick) begin
        m_phase = (m_phase + 1) % DUTY;
      end
    end else if (m_mode == 2) begin
      if (stop) begin
        m_mode = 0; m_tclr = 1;
      end else if (start && door_closed) begin
        m_mode = 1; m_power = level(int'(power_sel));
      end
    end else begin
      if (start || stop) m_mode = 0;
      else if (tick) begin
        m_beep = m_beep - 1;
        if (m_beep == 0) m_mode = 0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic pulse_tick();
    tick = 1'b1; step(); tick = 1'b0;
  endtask

  task automatic begin_cook(input logic [3:0] p);
    door_closed = 1'b1; timer_zero = 1'b0; power_sel = p;
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic end_cook();
    clear = 1'b1; step(); clear = 1'b0; step();
  endtask

  task automatic test_reset();
    rst = 1'b1; step(); step(); rst = 1'b0;
    checks++;
    if ({mag_on, count_en, timer_clear, beep, busy} !== 5'b0) begin
      failures++; $display("FAIL reset_outputs: got %b want 00000", {mag_on, count_en, timer_clear, beep, busy});
    end
    for (int i = 0; i < 5; i++) begin
      pulse_tick();
      checks++;
      if ({mag_on, count_en, timer_clear, beep, busy} !== 5'b0) begin
        failures++; $display("FAIL idle_tick%0d: got %b want 00000", i, {mag_on, count_en, timer_clear, beep, busy});
      end
    end
    timer_zero = 1'b1; start = 1'b1; step(); start = 1'b0; timer_zero = 1'b0; step();
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL start_timer_zero: busy got %b want 0", busy);
    end
  endtask

  task automatic test_power3();
    int on;
    begin_cook(4'd3);
    checks++;
    if (count_en !== 1'b1) begin
      failures++; $display("FAIL p3_count_en: got %b want 1", count_en);
    end
    for (int w = 0; w < 3; w++) begin
      on = 0;
      for (int i = 0; i < DUTY; i++) begin
        if (mag_on === 1'b1) on++;
        pulse_tick();
      end
      checks++;
      if (on != 3) begin
        failures++; $display("FAIL p3_window%0d: mag_on ticks got %0d want 3", w, on);
      end
    end
    clear = 1'b1; step(); clear = 1'b0;
    checks++;
    if (timer_clear !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL clear_pulse: tclr/busy got %b%b want 10", timer_clear, busy);
    end
    step();
    checks++;
    if (timer_clear !== 1'b0) begin
      failures++; $display("FAIL clear_width: got %b want 0", timer_clear);
    end
  endtask

  task automatic test_door_pause();
    begin_cook(4'd10);
    for (int i = 0; i < 4; i++) pulse_tick();
    door_closed = 1'b0; #1;
    checks++;
    if (mag_on !== 1'b0 || count_en !== 1'b1) begin
      failures++; $display("FAIL door_same_cycle: mag/cnt got %b%b want 01", mag_on, count_en);
    end
    step();
    checks++;
    if (count_en !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL door_paused: cnt/busy got %b%b want 01", count_en, busy);
    end
    door_closed = 1'b1; step();
    begin_cook(4'd5);
    checks++;
    if (count_en !== 1'b1 || mag_on !== 1'b1) begin
      failures++; $display("FAIL resume: cnt/mag got %b%b want 11", count_en, mag_on);
    end
    pulse_tick();
    checks++;
    if (mag_on !== 1'b0) begin
      failures++; $display("FAIL phase_preserved: mag_on got %b want 0", mag_on);
    end
    end_cook();
  endtask

  task automatic test_done_beep();
    int n = 0;
    bit gone = 0;
    begin_cook(4'd7);
    pulse_tick(); pulse_tick();
    timer_zero = 1'b1; step(); timer_zero = 1'b0;
    checks++;
    if (beep !== 1'b1 || count_en !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL done_entry: beep/cnt/busy got %b%b%b want 101", beep, count_en, busy);
    end
    for (int k = 0; k < 8 && !gone; k++) begin
      pulse_tick(); step();
      n++;
      if (beep === 1'b0) gone = 1;
    end
    checks++;
    if (n != BEEPS || !gone || busy !== 1'b0) begin
      failures++; $display("FAIL beep_len: ticks got %0d want %0d (busy %b)", n, BEEPS, busy);
    end
  endtask

  task automatic test_cancel_and_clear();
    begin_cook(4'd4);
    stop = 1'b1; step(); stop = 1'b0;
    checks++;
    if (count_en !== 1'b0 || busy !== 1'b1 || timer_clear !== 1'b0) begin
      failures++; $display("FAIL stop_pause: cnt/busy/tclr got %b%b%b want 010", count_en, busy, timer_clear);
    end
    stop = 1'b1; step(); stop = 1'b0;
    checks++;
    if (timer_clear !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL cancel: tclr/busy got %b%b want 10", timer_clear, busy);
    end
    step();
    checks++;
    if (timer_clear !== 1'b0) begin
      failures++; $display("FAIL cancel_width: got %b want 0", timer_clear);
    end
    begin_cook(4'd4);
    clear = 1'b1; timer_zero = 1'b1; step(); clear = 1'b0; timer_zero = 1'b0;
    checks++;
    if (timer_clear !== 1'b1 || beep !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL clear_vs_zero: tclr/beep/busy got %b%b%b want 100", timer_clear, beep, busy);
    end
    step();
  endtask

  task automatic test_clamp();
    logic [3:0] sels [2];
    sels[0] = 4'd0; sels[1] = 4'd15;
    for (int s = 0; s < 2; s++) begin
      begin_cook(sels[s]);
      power_sel = 4'd5;
      for (int i = 0; i < 12; i++) begin
        checks++;
        if (mag_on !== 1'b1) begin
          failures++; $display("FAIL clamp_sel%0d_t%0d: mag_on got %b want 1", sels[s], i, mag_on);
        end
        pulse_tick();
      end
      end_cook();
    end
  endtask

  task automatic test_reset_midcook();
    begin_cook(4'd10);
    pulse_tick();
    checks++;
    if (mag_on !== 1'b1) begin
      failures++; $display("FAIL midcook_on: mag_on got %b want 1", mag_on);
    end
    rst = 1'b1; step();
    checks++;
    if ({mag_on, count_en, timer_clear, beep, busy} !== 5'b0) begin
      failures++; $display("FAIL midcook_reset: got %b want 00000", {mag_on, count_en, timer_clear, beep, busy});
    end
    rst = 1'b0; step();
  endtask

  task automatic test_random();
    logic [4:0] want;
    for (int c = 0; c < 3000; c++) begin
      rst         = ($urandom_range(0, 299) == 0);
      tick        = ($urandom_range(0, 2) == 0);
      start       = ($urandom_range(0, 7) == 0);
      stop        = ($urandom_range(0, 15) == 0);
      clear       = ($urandom_range(0, 39) == 0);
      door_closed = ($urandom_range(0, 15) != 0);
      timer_zero  = ($urandom_range(0, 24) == 0);
      power_sel   = 4'($urandom_range(0, 15));
      #1;
      want = {(m_mode == 1) && (m_phase < m_power) && door_closed, m_mode == 1, m_tclr, m_mode == 3, m_mode != 0};
      checks++;
      if ({mag_on, count_en, timer_clear, beep, busy} !== want) begin
        failures++; $display("FAIL random_c%0d: mag/cnt/tclr/beep/busy got %b want %b", c, {mag_on, count_en, timer_clear, beep, busy}, want);
      end
      step();
    end
    rst = 1'b0; tick = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
    door_closed = 1'b1; timer_zero = 1'b0;
  endtask

  initial begin
    test_reset();
    test_power3();
    test_door_pause();
    test_done_beep();
    test_cancel_and_clear();
    test_clamp();
    test_reset_midcook();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
